mult_control: RTL and testbench



---
 rtl/mult_pkg.sv | 21 ++
 rtl/mult_control.sv | 125 ++++++++++++
 tb/tb_mult_control.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_pkg
// Description : Shared definitions for the shift-add multiplier. Holds the
//               control FSM state encoding and the default operand width
//               used by the controller, accumulator and adder.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Default multiplier / multiplicand width.
    localparam int MULT_N = 4;

    // Control FSM state encoding (2-bit).
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_control.sv
`default_nettype none
// ============================================================================
// Module      : mult_control
// Description : Control FSM for the shift-add multiplier. Issues load, add
//               and shift strobes to the accumulator, inspecting the current
//               multiplier LSB to choose add-then-shift or shift-only per bit,
//               and reports completion with a four-phase start/done handshake.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   st     in   start request (level), sampled in IDLE and DONE only
//   m      in   current multiplier LSB (accumulator bit 0)
//   load   out  load multiplier into accumulator, clear upper bits
//   ad     out  write adder result into accumulator upper N+1 bits
//   sh     out  shift accumulator right by one
//   busy   out  high in CHECK and SHIFT
//   done   out  product valid; high in DONE
// ============================================================================
module mult_control
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic clk,
    input  logic rst_n,
    input  logic st,
    input  logic m,
    output logic load,
    output logic ad,
    output logic sh,
    output logic busy,
    output logic done
);

    // Shift-counter width; guarded so a 1-bit multiplier still gets a counter.
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(N - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic w_load, w_ad, w_sh, w_busy, w_done;
    logic w_last;

    assign w_last = (cnt_q == C_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and Mealy control strobes. Strobes are valid during the
    // cycle preceding the edge on which the accumulator acts on them.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_load  = 1'b0;
        w_ad    = 1'b0;
        w_sh    = 1'b0;
        w_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                w_load = st;
                if (st) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end
            end
            ST_CHECK: begin
                if (m) begin
                    w_ad    = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    w_sh = 1'b1;
                    // Last bit: go to DONE and leave the counter parked at N-1.
                    if (w_last) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            ST_SHIFT: begin
                w_sh = 1'b1;
                if (w_last) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    state_d = ST_CHECK;
                end
            end
            ST_DONE: begin
                w_done = 1'b1;
                // Holding st high keeps the product visible; a new start
                // requires st to be seen low here first.
                if (!st) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign w_busy = (state_q == ST_CHECK) || (state_q == ST_SHIFT);

    // Gating with rst_n keeps every output low for the whole reset pulse,
    // including the combinational path from st to load.
    assign load = w_load & rst_n;
    assign ad   = w_ad   & rst_n;
    assign sh   = w_sh   & rst_n;
    assign busy = w_busy & rst_n;
    assign done = w_done & rst_n;

endmodule : mult_control
`default_nettype wire

// File: tb/tb_mult_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_control
// Description : Scoreboard bench for mult_control. Stimulus pushes the
//               expected control-event sequence (with cycle offsets from the
//               load cycle) into a queue; a monitor pops and compares each
//               load/ad/sh/done event. A small accumulator model closes the
//               loop, feeding m and checking the final product.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_control;
    import mult_pkg::*;

    logic clk;
    logic rst_n;
    logic st;
    logic m;
    logic load, ad, sh, busy, done;

    mult_control #(.N(MULT_N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .st    (st),
        .m     (m),
        .load  (load),
        .ad    (ad),
        .sh    (sh),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int code;   // 1=load 2=ad 3=sh 4=done
        int cyc;    // cycle offset from the load cycle
        int prod;   // done only: required accumulator value
        int nbusy;  // done only: required number of busy cycles
    } exp_t;

    exp_t exp_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int base        = 0;
    int busy_cnt    = 0;
    logic done_d    = 1'b0;

    logic [8:0] acc   = '0;
    logic [3:0] mult_r = '0;
    logic [3:0] mcand  = '0;

    // Accumulator model: 9 bits, multiplier in the low nibble.
    always @(posedge clk) begin
        if (rst_n) begin
            if (load)
                acc <= {5'b0, mult_r};
            else if (ad)
                acc <= {acc[8:4] + {1'b0, mcand}, acc[3:0]};
            else if (sh)
                acc <= acc >> 1;
        end
    end
    assign m = acc[0];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic string cname(input int c);
        case (c)
            1:       return "load";
            2:       return "ad";
            3:       return "sh";
            4:       return "done";
            default: return "none";
        endcase
    endfunction

    task automatic check_ev(input int code);
        exp_t e;
        int   rel;
        rel = cyc - base;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: got %s at cycle %0d, required no event", cname(code), rel);
        end else begin
            e = exp_q.pop_front();
            if (e.code != code || e.cyc != rel) begin
                miscompares++;
                $display("FAIL ctrl_seq: got %s at cycle %0d, required %s at cycle %0d",
                         cname(code), rel, cname(e.code), e.cyc);
            end
            if (code == 4) begin
                vectors++;
                if (int'(acc) != e.prod) begin
                    miscompares++;
                    $display("FAIL product: got %0d, required %0d", acc, e.prod);
                end
                vectors++;
                if (busy_cnt != e.nbusy) begin
                    miscompares++;
                    $display("FAIL busy_cycles: got %0d, required %0d", busy_cnt, e.nbusy);
                end
            end
        end
    endtask

    // Monitor: samples on the falling edge, away from the acting edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (load) base = cyc;
            if (load | ad | sh) begin
                vectors++;
                if ((int'(load) + int'(ad) + int'(sh)) > 1) begin
                    miscompares++;
                    $display("FAIL exclusive: got load=%0b ad=%0b sh=%0b, required one-hot", load, ad, sh);
                end
            end
            if (load) check_ev(1);
            if (ad)   check_ev(2);
            if (sh)   check_ev(3);
            if (load)      busy_cnt = 0;
            else if (busy) busy_cnt++;
            if (done && !done_d) check_ev(4);
            done_d = done;
        end else begin
            done_d = 1'b0;
        end
    end

    // Expected sequence: load@0, then per multiplier bit (LSB first) an
    // optional ad followed by one sh; done at the hand-computed cycle.
    task automatic push_seq(input logic [3:0] mult, input int prod, input int done_at);
        int c;
        exp_q.push_back('{1, 0, 0, 0});
        c = 1;
        for (int i = 0; i < 4; i++) begin
            if (mult[i]) begin
                exp_q.push_back('{2, c, 0, 0});
                c++;
            end
            exp_q.push_back('{3, c, 0, 0});
            c++;
        end
        exp_q.push_back('{4, done_at, prod, done_at - 1});
    endtask

    task automatic check_idle(input string name);
        vectors++;
        if ({load, ad, sh, busy, done} !== 5'b0) begin
            miscompares++;
            $display("FAIL %s: got load/ad/sh/busy/done=%b, required 00000", name, {load, ad, sh, busy, done});
        end
    endtask

    task automatic run(input logic [3:0] mult, input logic [3:0] mc, input int prod,
                       input int done_at, input int hold, input bit keep_st, input bit glitch);
        int t;
        mult_r = mult;
        mcand  = mc;
        push_seq(mult, prod, done_at);
        @(posedge clk); #1;
        st = 1'b1;
        #1;
        vectors++;
        if (load !== 1'b1) begin
            miscompares++;
            $display("FAIL load_same_cycle: got %b, required 1", load);
        end
        if (!keep_st) begin
            @(posedge clk); #1 st = 1'b0;
        end
        if (glitch) begin
            @(posedge clk);
            @(posedge clk); #1 st = 1'b0;
            @(posedge clk); #1 st = 1'b1;
        end
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 20);
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL done_timeout: got done=0 after %0d cycles, required done=1", t);
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            vectors++;
            if (done !== 1'b1 || load !== 1'b0) begin
                miscompares++;
                $display("FAIL done_hold: got done=%b load=%b, required done=1 load=0", done, load);
            end
        end
        if (keep_st) begin
            @(posedge clk); #1 st = 1'b0;
        end
        @(posedge clk); #1;
        check_idle("back_to_idle");
    endtask

    initial begin
        rst_n = 1'b0;
        st    = 1'b1;
        #2;
        check_idle("reset_forced");
        @(posedge clk);
        @(posedge clk); #1;
        st    = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // 1011 x 1101 with st held through DONE for 3 extra cycles.
        run(4'b1101, 4'b1011, 143, 8, 3, 1'b1, 1'b0);
        // 1011 x 0000: shifts only, st dropped after one cycle.
        run(4'b0000, 4'b1011, 0, 5, 0, 1'b0, 1'b0);
        // 1011 x 1111: add+shift for every bit.
        run(4'b1111, 4'b1011, 165, 9, 3, 1'b1, 1'b0);
        // Glitch on st during busy: sequence unchanged, no re-load.
        run(4'b1101, 4'b1011, 143, 8, 0, 1'b1, 1'b1);

        // Reset in the middle of a multiplication.
        mult_r = 4'b1111;
        mcand  = 4'b1011;
        push_seq(4'b1111, 165, 9);
        @(posedge clk); #1 st = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b1 || ad !== 1'b1) begin
            miscompares++;
            $display("FAIL in_check: got busy=%b ad=%b, required busy=1 ad=1", busy, ad);
        end
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_idle("async_reset");
        @(posedge clk); #1 st = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        check_idle("idle_after_reset_1");
        @(negedge clk);
        check_idle("idle_after_reset_2");

        // Recovery: 0111 x 1010 = 70, latency 1+4+2.
        run(4'b1010, 4'b0111, 70, 7, 1, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover_events: got %0d pending, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion by 100000, required $finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_mult_control
`default_nettype wire
